// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma keypress sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: ALPHA, letter_t, onehot_t, step_state_t, inc26, sanitize26, letter_onehot.
package enigma_pkg;

  localparam int ALPHA = 26;

  typedef logic [4:0]       letter_t;
  typedef logic [ALPHA-1:0] onehot_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } step_state_t;

  // Rotor advance modulo 26 (25 wraps to 0).
  function automatic letter_t inc26(input letter_t x);
    return (x >= letter_t'(ALPHA - 1)) ? '0 : x + 5'd1;
  endfunction

  // Out-of-alphabet load values are forced to 0.
  function automatic letter_t sanitize26(input letter_t x);
    return (x > letter_t'(ALPHA - 1)) ? '0 : x;
  endfunction

  function automatic onehot_t letter_onehot(input letter_t x);
    return onehot_t'(1) << x;
  endfunction

endpackage

// File: rtl/enigma_step_ctrl_if.sv
// Bundle of all non-clock signals between the sequencer and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: KEY_VALID/KEY_READY on the input side, OUT_VALID/OUT_READY on the result side.
// Modports: slave = the sequencer, master = front end / rotor stack / consumer side.
interface enigma_step_ctrl_if;
  import enigma_pkg::*;

  logic          KEY_VALID;
  logic          KEY_READY;
  letter_t       KEY_IDX;
  logic          LOAD;
  logic [14:0]   LOAD_POS;   // {L, M, R}
  letter_t       POS_L;
  letter_t       POS_M;
  letter_t       POS_R;
  onehot_t       PATH_IN;
  onehot_t       PATH_OUT;
  logic          OUT_VALID;
  logic          OUT_READY;
  letter_t       OUT_IDX;
  logic          ERR;

  modport slave (
    input  KEY_VALID, KEY_IDX, LOAD, LOAD_POS, PATH_OUT, OUT_READY,
    output KEY_READY, POS_L, POS_M, POS_R, PATH_IN, OUT_VALID, OUT_IDX, ERR
  );

  modport master (
    output KEY_VALID, KEY_IDX, LOAD, LOAD_POS, PATH_OUT, OUT_READY,
    input  KEY_READY, POS_L, POS_M, POS_R, PATH_IN, OUT_VALID, OUT_IDX, ERR
  );

endinterface

// File: rtl/onehot_encode26.sv
// One-hot to letter index encoder with a single-hot flag.
// Latency: combinational.
// Backpressure: none.
// Ports: oh_i (26-bit one-hot), idx_o (highest set bit position), single_o (exactly one bit set).
module onehot_encode26
  import enigma_pkg::*;
(
  input  onehot_t oh_i,
  output letter_t idx_o,
  output logic    single_o
);

  logic [4:0] n_set;

  always_comb begin
    idx_o = '0;
    n_set = '0;
    for (int i = 0; i < ALPHA; i++) begin
      if (oh_i[i]) begin
        idx_o = letter_t'(i);
        n_set = n_set + 5'd1;
      end
    end
    single_o = (n_set == 5'd1);
  end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Keypress sequencer: steps three rotors (with double step), drives the letter into the rotor path, captures the result.
// Latency: key accepted at edge E0 -> positions/PATH_IN after E0+1 -> capture and OUT_VALID after E0+1+SETTLE_CYCLES.
// Backpressure: KEY_READY low outside IDLE (and while LOAD); OUT_READY low holds the result in DONE indefinitely.
// Ports: CLK, RST_N (async active-low); bus.slave carries key handshake, LOAD/LOAD_POS, POS_L/M/R,
//        PATH_IN/PATH_OUT, result handshake OUT_VALID/OUT_READY/OUT_IDX, and sticky ERR.
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int NOTCH_R       = 21,
  parameter int NOTCH_M       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  enigma_step_ctrl_if.slave bus
);

  typedef logic [7:0] cnt_t;

  localparam letter_t NR       = letter_t'(NOTCH_R);
  localparam letter_t NM       = letter_t'(NOTCH_M);
  localparam cnt_t    CNT_INIT = cnt_t'(SETTLE_CYCLES - 1);

  step_state_t state_q, state_d;
  letter_t     pos_l_q, pos_l_d;
  letter_t     pos_m_q, pos_m_d;
  letter_t     pos_r_q, pos_r_d;
  letter_t     idx_q, idx_d;
  letter_t     out_idx_q, out_idx_d;
  cnt_t        cnt_q, cnt_d;
  logic        err_q, err_d;

  letter_t     enc_idx;
  logic        enc_single;

  logic        key_fire;
  logic        key_ok;
  logic        settle_done;

  onehot_encode26 u_enc (
    .oh_i     (bus.PATH_OUT),
    .idx_o    (enc_idx),
    .single_o (enc_single)
  );

  // LOAD masks the key handshake so it wins when both arrive together.
  assign key_fire    = (state_q == IDLE) && bus.KEY_VALID && !bus.LOAD;
  assign key_ok      = (bus.KEY_IDX <= letter_t'(ALPHA - 1));
  assign settle_done = (state_q == SETTLE) && (cnt_q == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (key_fire && key_ok) state_d = STEP;
      STEP:    state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = DONE;
      DONE:    if (bus.OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.KEY_READY = 1'b0;
    bus.OUT_VALID = 1'b0;
    bus.PATH_IN   = '0;
    unique case (state_q)
      IDLE:    bus.KEY_READY = !bus.LOAD;
      SETTLE:  bus.PATH_IN   = letter_onehot(idx_q);
      DONE:    bus.OUT_VALID = 1'b1;
      default: ;
    endcase
  end

  assign bus.POS_L   = pos_l_q;
  assign bus.POS_M   = pos_m_q;
  assign bus.POS_R   = pos_r_q;
  assign bus.OUT_IDX = out_idx_q;
  assign bus.ERR     = err_q;

  // ---------------- Datapath next state ----------------
  always_comb begin
    pos_l_d   = pos_l_q;
    pos_m_d   = pos_m_q;
    pos_r_d   = pos_r_q;
    idx_d     = idx_q;
    out_idx_d = out_idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.LOAD) begin
          pos_l_d = sanitize26(bus.LOAD_POS[14:10]);
          pos_m_d = sanitize26(bus.LOAD_POS[9:5]);
          pos_r_d = sanitize26(bus.LOAD_POS[4:0]);
          err_d   = 1'b0;
        end else if (key_fire) begin
          // Bad letters are swallowed: flag and stay idle.
          if (key_ok) idx_d = bus.KEY_IDX;
          else        err_d = 1'b1;
        end
      end
      STEP: begin
        // All conditions use pre-step positions. M moving when it already sits on
        // its own notch is the double-step anomaly.
        pos_r_d = inc26(pos_r_q);
        if ((pos_r_q == NR) || (pos_m_q == NM)) pos_m_d = inc26(pos_m_q);
        if (pos_m_q == NM)                      pos_l_d = inc26(pos_l_q);
        cnt_d = CNT_INIT;
      end
      SETTLE: begin
        if (settle_done) begin
          // A broken path (no or multiple bits) still yields a result, as letter 0.
          out_idx_d = enc_single ? enc_idx : '0;
          if (!enc_single) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pos_l_q   <= '0;
      pos_m_q   <= '0;
      pos_r_q   <= '0;
      idx_q     <= '0;
      out_idx_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pos_l_q   <= pos_l_d;
      pos_m_q   <= pos_m_d;
      pos_r_q   <= pos_r_d;
      idx_q     <= idx_d;
      out_idx_q <= out_idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Scoreboarded directed bench for enigma_step_ctrl.
// Stimulus drives at posedge+1, all sampling on the falling edge.
// Expected results are queued at key acceptance and checked by an independent monitor.
module tb_enigma_step_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;
  int   path_mode;   // 0: letter shifted by 7, 1: constant 26'h3

  typedef struct {
    int idx;
    int err;
  } exp_t;
  exp_t exp_q[$];

  enigma_step_ctrl_if bus();

  enigma_step_ctrl #(
    .NOTCH_R(21), .NOTCH_M(4), .SETTLE_CYCLES(2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Stand-in rotor path: letter i comes back as (i+7) mod 26.
  always_comb begin
    bus.PATH_OUT = '0;
    if (path_mode == 1) begin
      bus.PATH_OUT = 26'h3;
    end else begin
      for (int i = 0; i < 26; i++)
        if (bus.PATH_IN[i]) bus.PATH_OUT[(i + 7) % 26] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pos(input string name, input int l, input int m, input int r);
    chk({name, "_L"}, 32'(bus.POS_L), l);
    chk({name, "_M"}, 32'(bus.POS_M), m);
    chk({name, "_R"}, 32'(bus.POS_R), r);
  endtask

  // Monitor: pop and compare on every result handshake.
  always @(negedge CLK) begin
    if (RST_N && bus.OUT_VALID && bus.OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual_idx=%0d required=no_output t=%0t", bus.OUT_IDX, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_out_idx", 32'(bus.OUT_IDX), e.idx);
        chk("sb_err", 32'(bus.ERR), e.err);
      end
    end
  end

  task automatic do_load(input int l, input int m, input int r);
    bus.LOAD     = 1'b1;
    bus.LOAD_POS = {5'(l), 5'(m), 5'(r)};
    @(negedge CLK);
    chk("load_krdy_low", 32'(bus.KEY_READY), 0);
    @(posedge CLK); #1;
    bus.LOAD = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen_idle = 0;
    for (int c = 0; c < 50 && !seen_idle; c++) begin
      @(negedge CLK);
      if (!bus.OUT_VALID) seen_idle = 1;
    end
    if (!seen_idle) chk("wait_idle_timeout", 32'(bus.OUT_VALID), 0);
    @(posedge CLK); #1;
  endtask

  // Called at posedge+1. Pushes the expected result at the accept edge.
  task automatic send_key(input int k, input int el, input int em, input int er,
                          input int eo, input int eerr, input bit hold);
    exp_t e;
    bus.KEY_VALID = 1'b1;
    bus.KEY_IDX   = 5'(k);
    @(negedge CLK);
    chk("key_rdy_idle", 32'(bus.KEY_READY), 1);
    @(posedge CLK);                       // E0
    e.idx = eo; e.err = eerr;
    exp_q.push_back(e);
    #1 bus.KEY_VALID = 1'b0;
    @(negedge CLK);                       // STEP
    chk("step_path_in", 32'(bus.PATH_IN), 0);
    chk("step_krdy", 32'(bus.KEY_READY), 0);
    @(negedge CLK);                       // after E0+1
    chk_pos("pos", el, em, er);
    chk("settle_path_in1", 32'(bus.PATH_IN), 32'(1) << k);
    @(negedge CLK);                       // after E0+2
    chk("settle_path_in2", 32'(bus.PATH_IN), 32'(1) << k);
    chk("settle_no_valid", 32'(bus.OUT_VALID), 0);
    @(negedge CLK);                       // after E0+3
    chk("out_valid_lat", 32'(bus.OUT_VALID), 1);
    chk("done_path_in", 32'(bus.PATH_IN), 0);
    if (!hold) wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N         = 1'b0;
    path_mode     = 0;
    bus.KEY_VALID = 1'b0;
    bus.KEY_IDX   = '0;
    bus.LOAD      = 1'b0;
    bus.LOAD_POS  = '0;
    bus.OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_krdy", 32'(bus.KEY_READY), 1);
    chk_pos("rst_pos", 0, 0, 0);
    chk("rst_path_in", 32'(bus.PATH_IN), 0);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 0);
    chk("rst_out_idx", 32'(bus.OUT_IDX), 0);
    chk("rst_err", 32'(bus.ERR), 0);
    @(posedge CLK); #1;

    // Single key
    do_load(0, 0, 0);
    send_key(0, 0, 0, 1, 7, 0, 0);

    // Double step
    do_load(0, 3, 20);
    send_key(1, 0, 3, 21, 8, 0, 0);
    send_key(2, 0, 4, 22, 9, 0, 0);
    send_key(3, 1, 5, 23, 10, 0, 0);

    // Wrap
    do_load(25, 25, 25);
    send_key(25, 25, 25, 0, 6, 0, 0);

    // Backpressure
    do_load(0, 0, 0);
    bus.OUT_READY = 1'b0;
    send_key(10, 0, 0, 1, 17, 0, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("bp_valid", 32'(bus.OUT_VALID), 1);
      chk("bp_idx", 32'(bus.OUT_IDX), 17);
      chk("bp_krdy", 32'(bus.KEY_READY), 0);
      chk("bp_path_in", 32'(bus.PATH_IN), 0);
      chk("bp_pos_r", 32'(bus.POS_R), 1);
    end
    @(posedge CLK); #1;
    bus.OUT_READY = 1'b1;
    wait_idle();

    // Broken path: two bits returned
    path_mode = 1;
    send_key(4, 0, 0, 2, 0, 1, 0);
    path_mode = 0;
    @(negedge CLK);
    chk("err_sticky_idle", 32'(bus.ERR), 1);
    @(posedge CLK); #1;
    send_key(5, 0, 0, 3, 12, 1, 0);
    do_load(0, 0, 0);
    @(negedge CLK);
    chk("err_cleared_by_load", 32'(bus.ERR), 0);
    @(posedge CLK); #1;

    // Out-of-range key
    bus.KEY_VALID = 1'b1;
    bus.KEY_IDX   = 5'd30;
    @(posedge CLK); #1;
    bus.KEY_VALID = 1'b0;
    @(negedge CLK);
    chk("badkey_err", 32'(bus.ERR), 1);
    chk("badkey_krdy", 32'(bus.KEY_READY), 1);
    chk_pos("badkey_pos", 0, 0, 0);
    @(negedge CLK);
    chk("badkey_no_step", 32'(bus.PATH_IN), 0);
    chk_pos("badkey_pos2", 0, 0, 0);
    @(posedge CLK); #1;

    // LOAD beats a simultaneous key; out-of-range load fields become 0
    bus.LOAD      = 1'b1;
    bus.LOAD_POS  = {5'd31, 5'd26, 5'd3};
    bus.KEY_VALID = 1'b1;
    bus.KEY_IDX   = 5'd3;
    @(negedge CLK);
    chk("prio_krdy", 32'(bus.KEY_READY), 0);
    @(posedge CLK); #1;
    bus.LOAD      = 1'b0;
    bus.KEY_VALID = 1'b0;
    @(negedge CLK);
    chk_pos("prio_pos", 0, 0, 3);
    chk("prio_err_clr", 32'(bus.ERR), 0);
    @(negedge CLK);
    chk("prio_no_step", 32'(bus.PATH_IN), 0);
    chk("prio_idle", 32'(bus.KEY_READY), 1);
    @(posedge CLK); #1;

    // Reset during SETTLE
    bus.KEY_VALID = 1'b1;
    bus.KEY_IDX   = 5'd6;
    @(posedge CLK); #1;
    bus.KEY_VALID = 1'b0;
    @(negedge CLK);                       // STEP
    @(negedge CLK);                       // SETTLE
    chk("mid_path_in_pre", 32'(bus.PATH_IN), 32'(1) << 6);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_path_in", 32'(bus.PATH_IN), 0);
    chk_pos("mid_rst_pos", 0, 0, 0);
    chk("mid_rst_valid", 32'(bus.OUT_VALID), 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("post_rst_no_valid", 32'(bus.OUT_VALID), 0);
    end
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_step_ctrl.md
# enigma_step_ctrl

Keypress sequencer for the Enigma datapath. It accepts one letter per valid/ready handshake and steps the three rotor positions, including the double-step anomaly. It then drives the letter one-hot into the rotor/reflector/rotor combinational path, waits a fixed settle time, and captures and encodes the returned one-hot. It sits between the keyboard/UART front end and the rotor stack, and owns the rotor position registers.

## Interface

Clocking: one clock; reset is asynchronous and active-low.

Parameters
- NOTCH_R, 21: right-rotor turnover position (0-25).
- NOTCH_M, 4: middle-rotor turnover position.
- SETTLE_CYCLES, 2: cycles PATH_IN is held before capture (≥1).

Ports
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- KEY_VALID  in  1  key request valid.
- KEY_READY  out  1  controller accepts key.
- KEY_IDX  in  5  letter index 0-25.
- LOAD  in  1  load rotor start positions.
- LOAD_POS  in  15  {L,M,R}, 5 bits each, 0-25.
- POS_L, POS_M, POS_R  out  5 each  current rotor positions, to rotor stack.
- PATH_IN  out  26  one-hot letter into rotor path.
- PATH_OUT  in  26  one-hot result returned from the path.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- OUT_IDX  out  5  encoded result letter.
- ERR  out  1  sticky error flag.

## Operation

- FSM states: IDLE, STEP, SETTLE, DONE.
- IDLE: KEY_READY = !LOAD.
  - LOAD=1: POS_{L,M,R} ← LOAD_POS fields, values above 25 reduced to 0, ERR cleared, state stays IDLE. LOAD has priority over KEY_VALID in the same cycle. LOAD is ignored outside IDLE.
  - KEY_VALID & KEY_READY with KEY_IDX ≤ 25: latch index, go to STEP.
  - KEY_VALID & KEY_READY with KEY_IDX > 25: consumed, ERR ← 1, stay in IDLE, no stepping.
- STEP, one cycle. All rotor conditions are evaluated on pre-step values.
  - R advances every press.
  - M advances if R == NOTCH_R or M == NOTCH_M (double step).
  - L advances if M == NOTCH_M.
  - Advance is mod 26: 25 → 0.
  - Go to SETTLE, counter ← SETTLE_CYCLES−1.
- SETTLE: PATH_IN = one-hot of latched index. The counter decrements each cycle. At 0, capture PATH_OUT, encode it, and go to DONE.
- DONE: OUT_VALID=1. OUT_IDX is stable until OUT_VALID & OUT_READY, then go to IDLE.
- Capture encoding:
  - Exactly one bit set: OUT_IDX = its position.
  - Zero or more than one bit set: OUT_IDX=0, ERR ← 1, result still delivered.
- PATH_IN = 0 in every state except SETTLE.
- ERR is sticky. It is cleared only by reset or LOAD.

## Timing

- Reset values:
  - State IDLE; KEY_READY=1 once RST_N is high.
  - POS_L/M/R = 0; PATH_IN = 0.
  - OUT_VALID = 0; OUT_IDX = 0; ERR = 0.
- Latency, with key accepted at edge E0:
  - Positions update and PATH_IN is driven after E0+1.
  - Capture occurs at edge E0+1+SETTLE_CYCLES.
  - OUT_VALID is high after that edge: 3 edges for the default SETTLE_CYCLES=2.
- Throughput: one key per 3+SETTLE_CYCLES cycles with OUT_READY tied high, since IDLE is revisited between keys. KEY_READY=0 in STEP, SETTLE and DONE.
- Backpressure: OUT_READY low holds DONE indefinitely. OUT_IDX, positions and PATH_IN=0 stay stable.
- Positions change only on the STEP→SETTLE edge or on LOAD in IDLE. They are stable throughout SETTLE.
- Reset mid-operation: immediate return to reset values. The in-flight key is lost and no OUT_VALID is produced.

## Structure

- Package enigma_pkg:
  - ALPHA = 26
  - letter_t = logic [4:0]
  - onehot_t = logic [25:0]
  - step_state_t enum {IDLE, STEP, SETTLE, DONE}
  - function inc26
- One sub-module, onehot_encode26: combinational onehot_t → letter_t plus a single-hot flag, used at capture.
- Datapath blocks are instantiated outside this controller and connect via POS_* and PATH_IN/PATH_OUT.

## Test plan

- Reset then idle: after RST_N rises, KEY_READY=1, POS=0,0,0, PATH_IN=0, OUT_VALID=0, ERR=0.
- Single key: LOAD {0,0,0}; key 0; bench returns PATH_OUT = 1<<7 while PATH_IN[0] is set.
  - Expect POS=0,0,1 and PATH_IN=26'h1 for 2 cycles.
  - Expect OUT_VALID 3 edges after accept, with OUT_IDX=7.
- Double step: LOAD {0,3,20}; three keys.
  - Expect positions {0,3,21} → {0,4,22} → {1,5,23}.
- Wrap: LOAD {25,25,25} with default notches; one key.
  - Expect {25,25,0}. L and M do not advance because R=25 ≠ 21 and M=25 ≠ 4.
- Backpressure and bad input:
  - Hold OUT_READY=0 for 10 cycles: OUT_VALID and OUT_IDX stay stable and KEY_READY stays 0.
  - PATH_OUT = 26'h3: OUT_IDX=0 and ERR=1. ERR stays 1 until LOAD clears it.
  - KEY_IDX=30: ERR=1 with no position change.
- Reset mid-SETTLE: assert RST_N=0 during SETTLE.
  - Expect immediate PATH_IN=0, POS=0, and no OUT_VALID after release.
